// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO peripheral: register offsets, pin modes,
// bus handshake states and byte-lane helpers.
package gpio_pkg;

  localparam logic [4:0] GPIO_CTRL    = 5'h00;
  localparam logic [4:0] GPIO_DATA    = 5'h04;
  localparam logic [4:0] GPIO_RISE_EN = 5'h08;
  localparam logic [4:0] GPIO_FALL_EN = 5'h0C;
  localparam logic [4:0] GPIO_PEND    = 5'h10;

  typedef enum logic [1:0] {
    MODE_HIZ  = 2'b00,
    MODE_OUT  = 2'b01,
    MODE_IN   = 2'b10,
    MODE_RSVD = 2'b11
  } gpio_mode_e;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [31:0] mask);
    return (old & ~mask) | (wdata & mask);
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-pin pad synchroniser plus a one-cycle history flop for edge detection.
module gpio_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/gpio_irq.sv
// GPIO peripheral on the req/addr_ok/data_ok bus: per-pin mode, data,
// edge-triggered sticky pending flags and a registered OR-reduced interrupt.
module gpio_irq
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_IO         = 2,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned RAM_MASK_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               data_i,
  input  logic [RAM_MASK_WIDTH-1:0] wem,
  output logic [31:0]               data_o,
  output logic                      addr_ok,
  output logic                      data_ok,
  input  logic [NUM_IO-1:0]         io_pin_i,
  output logic [NUM_IO-1:0]         io_out_o,
  output logic [NUM_IO-1:0]         io_oe_o,
  output logic                      irq_o
);

  localparam int unsigned CW = 2 * NUM_IO;

  logic [CW-1:0]     ctrl;
  logic [NUM_IO-1:0] data_r, rise_en, fall_en, pend;
  logic [NUM_IO-1:0] sync, rise, fall, mode_in, oe;
  logic [NUM_IO-1:0] set, clr, data_wr, data_next;
  logic              accept, wr, rd;
  logic [31:0]       mask, rdata, data_q;
  logic              irq_q;
  logic              unused_addr;
  bus_state_e        state, state_next;

  assign addr_ok     = !rst;
  assign accept      = req_i & addr_ok;
  assign wr          = accept & we_i;
  assign rd          = accept & ~we_i;
  assign mask        = byte_mask(4'(wem));
  assign unused_addr = ^addr_i[31:5];

  for (genvar i = 0; i < NUM_IO; i++) begin : g_pin
    gpio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .clk  (clk),
      .rst  (rst),
      .pin  (io_pin_i[i]),
      .sync (sync[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
    assign mode_in[i] = (gpio_mode_e'(ctrl[2*i +: 2]) == MODE_IN);
    assign oe[i]      = (gpio_mode_e'(ctrl[2*i +: 2]) == MODE_OUT);
  end

  // Bus handshake: every accepted request is acknowledged on the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BUS_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = accept ? BUS_ACK : BUS_IDLE;
  end

  always_comb begin
    data_ok = (state == BUS_ACK);
  end

  always_comb begin
    rdata = '0;
    case (addr_i[4:0])
      GPIO_CTRL:    rdata = 32'(ctrl);
      GPIO_DATA:    rdata = 32'(data_r);
      GPIO_RISE_EN: rdata = 32'(rise_en);
      GPIO_FALL_EN: rdata = 32'(fall_en);
      GPIO_PEND:    rdata = 32'(pend);
      default:      rdata = '0;
    endcase
  end

  // Input-mode pins track the synchronised pad, overriding any CPU write.
  always_comb begin
    data_wr = data_r;
    if (wr && addr_i[4:0] == GPIO_DATA)
      data_wr = NUM_IO'(lane_merge(32'(data_r), data_i, mask));
    data_next = (mode_in & sync) | (~mode_in & data_wr);
  end

  always_comb begin
    set = mode_in & ((rise & rise_en) | (fall & fall_en));
    clr = '0;
    if (wr && addr_i[4:0] == GPIO_PEND)
      clr = NUM_IO'(data_i & mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl    <= '0;
      data_r  <= '0;
      rise_en <= '0;
      fall_en <= '0;
      pend    <= '0;
      data_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (wr && addr_i[4:0] == GPIO_CTRL)
        ctrl <= CW'(lane_merge(32'(ctrl), data_i, mask));
      if (wr && addr_i[4:0] == GPIO_RISE_EN)
        rise_en <= NUM_IO'(lane_merge(32'(rise_en), data_i, mask));
      if (wr && addr_i[4:0] == GPIO_FALL_EN)
        fall_en <= NUM_IO'(lane_merge(32'(fall_en), data_i, mask));
      data_r <= data_next;
      pend   <= (pend & ~clr) | set;
      data_q <= rd ? rdata : '0;
      irq_q  <= |pend;
    end
  end

  assign data_o   = data_q;
  assign irq_o    = irq_q;
  assign io_oe_o  = oe;
  assign io_out_o = data_r & oe;

endmodule

// File: tb/tb_gpio_irq.sv
// Scoreboarded bench for gpio_irq with four pins: bus acks and read data are
// checked against expectations queued when each request is driven.
module tb_gpio_irq;

  localparam int unsigned N = 4;

  localparam logic [4:0] A_CTRL = 5'h00;
  localparam logic [4:0] A_DATA = 5'h04;
  localparam logic [4:0] A_RISE = 5'h08;
  localparam logic [4:0] A_FALL = 5'h0C;
  localparam logic [4:0] A_PEND = 5'h10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic         we = 1'b0;
  logic [31:0]  addr = '0;
  logic [31:0]  wdata = '0;
  logic [3:0]   wem = '0;
  logic [31:0]  rdata;
  logic         addr_ok, data_ok, irq;
  logic [N-1:0] pins = '0;
  logic [N-1:0] io_out, io_oe;

  gpio_irq #(.NUM_IO(N), .SYNC_STAGES(2), .RAM_MASK_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .we_i     (we),
    .addr_i   (addr),
    .data_i   (wdata),
    .wem      (wem),
    .data_o   (rdata),
    .addr_ok  (addr_ok),
    .data_ok  (data_ok),
    .io_pin_i (pins),
    .io_out_o (io_out),
    .io_oe_o  (io_oe),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] exp;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input bit w, input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [31:0] exp);
    @(negedge clk);
    req   = 1'b1;
    we    = w;
    addr  = {27'h0, a};
    wdata = d;
    wem   = m;
    sb.push_back('{rd: !w, exp: exp, cyc: cyc});
    @(posedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    issue(1'b1, a, d, m, '0);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp);
    issue(1'b0, a, '0, '0, exp);
  endtask

  task automatic idle(input int unsigned n);
    @(negedge clk);
    req = 1'b0;
    we  = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (data_ok) begin
        if (sb.size() == 0) begin
          check("spurious_ack", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("ack_latency", cyc, e.cyc + 1);
          if (e.rd) check("rd_data", rdata, e.exp);
        end
      end else begin
        check("idle_data_o", rdata, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    check("rst_data_o", rdata, 0);
    check("rst_data_ok", 32'(data_ok), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_oe", 32'(io_oe), 0);
    check("rst_addr_ok", 32'(addr_ok), 0);
    rst = 1'b0;
    #1 check("addr_ok_up", 32'(addr_ok), 1);

    // output path
    wr(A_CTRL, 32'h55, 4'hF);
    wr(A_DATA, 32'hA, 4'hF);
    idle(1);
    #1;
    check("out_oe", 32'(io_oe), 32'hF);
    check("out_val", 32'(io_out), 32'hA);
    rd(A_DATA, 32'hA);

    // byte lanes and read-only upper bits
    wr(A_CTRL, 32'hFFFF_FFFF, 4'b0001);
    rd(A_CTRL, 32'hFF);
    wr(A_CTRL, 32'h0000_AA00, 4'b0010);
    wr(A_CTRL, 32'h0000_0000, 4'b0000);
    rd(A_CTRL, 32'hFF);
    idle(1);
    #1 check("rsvd_oe", 32'(io_oe), 0);

    // rising edge interrupt latency
    wr(A_CTRL, 32'h2, 4'hF);
    wr(A_RISE, 32'h1, 4'hF);
    rd(A_PEND, 32'h0);
    idle(3);
    @(negedge clk) pins[0] = 1'b1;
    for (int unsigned i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1 check("irq_latency", 32'(irq), (i == 4) ? 32'd1 : 32'd0);
    end
    rd(A_PEND, 32'h1);
    wr(A_PEND, 32'h1, 4'hF);
    idle(2);
    @(negedge clk) pins[0] = 1'b0;
    idle(6);
    check("fall_ignored_irq", 32'(irq), 0);
    rd(A_PEND, 32'h0);

    // clear colliding with a new edge: set wins
    idle(1);
    @(negedge clk) pins[0] = 1'b1;
    idle(6);
    @(negedge clk) pins[0] = 1'b0;
    idle(6);
    check("pend_held_irq", 32'(irq), 1);
    @(negedge clk) pins[0] = 1'b1;
    repeat (2) @(posedge clk);
    wr(A_PEND, 32'h1, 4'hF);
    idle(3);
    check("collide_irq", 32'(irq), 1);
    rd(A_PEND, 32'h1);
    wr(A_PEND, 32'h1, 4'hF);
    #1 check("clr_irq_lag", 32'(irq), 1);
    idle(1);
    #1 check("clr_irq", 32'(irq), 0);
    rd(A_PEND, 32'h0);

    // input override and unmapped offsets
    wr(A_CTRL, 32'h8, 4'hF);
    wr(A_RISE, 32'h3, 4'hF);
    idle(1);
    #1 check("in_oe", 32'(io_oe), 0);
    @(negedge clk) pins[1] = 1'b1;
    idle(5);
    wr(A_DATA, 32'h0, 4'hF);
    rd(A_DATA, 32'h2);
    rd(5'h14, 32'h0);
    wr(5'h18, 32'hFFFF_FFFF, 4'hF);
    rd(A_CTRL, 32'h8);
    rd(A_RISE, 32'h3);
    rd(A_FALL, 32'h0);
    rd(A_PEND, 32'h2);

    // reset in the middle of a read ack
    wr(A_CTRL, 32'h19, 4'hF);
    wr(A_DATA, 32'hF, 4'hF);
    idle(2);
    check("pre_oe", 32'(io_oe), 32'h5);
    check("pre_out", 32'(io_out), 32'h5);
    check("pre_irq", 32'(irq), 1);
    rd(A_CTRL, 32'h19);
    #1 check("pre_rst_data", rdata, 32'h19);
    req = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_data_o", rdata, 0);
    check("mid_rst_data_ok", 32'(data_ok), 0);
    check("mid_rst_irq", 32'(irq), 0);
    check("mid_rst_oe", 32'(io_oe), 0);
    check("mid_rst_out", 32'(io_out), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(A_CTRL, 32'h0);
    rd(A_PEND, 32'h0);
    idle(3);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_irq.md
Name: gpio_irq

Overview:
- Parametrised GPIO peripheral on the core's simple req/addr_ok/data_ok peripheral bus.
- Supports up to 16 pins, each with a 2-bit mode: hi-Z, output, or input.
- Input pins pass through a 2-flop synchroniser. Each pin has per-pin rising/falling edge detection, a sticky pending flag and an OR-reduced interrupt line to the core.

Parameters:
- NUM_IO, 2, number of pins (1..16).
- SYNC_STAGES, 2, synchroniser depth (2..3).
- RAM_MASK_WIDTH, 4, byte write-enable width, matches the core's global define.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req_i  input  1  bus request.
- we_i  input  1  1 = write, 0 = read.
- addr_i  input  32  byte address; [4:0] decoded.
- data_i  input  32  write data.
- wem  input  RAM_MASK_WIDTH  byte write enables.
- data_o  output  32  read data, registered.
- addr_ok  output  1  request accepted.
- data_ok  output  1  read data valid or write done.
- io_pin_i  input  NUM_IO  raw pad inputs (asynchronous).
- io_out_o  output  NUM_IO  pad output values.
- io_oe_o  output  NUM_IO  pad output enables.
- irq_o  output  1  level interrupt.

Behaviour:
- Reset is asynchronous, active-high. While rst=1: all registers, data_o, data_ok, irq_o, io_out_o, io_oe_o and the synchroniser flops are 0. addr_ok = !rst.
- Register map (addr_i[4:0]):
  - 0x00 CTRL: 2 bits per pin. 00 = hi-Z, 01 = output, 10 = input, 11 = reserved (treated as hi-Z).
  - 0x04 DATA
  - 0x08 RISE_EN
  - 0x0C FALL_EN
  - 0x10 PEND: write-1-to-clear.
  - Bits at or above NUM_IO (2*NUM_IO for CTRL) are read-only 0.
- Accept: a request is accepted on a cycle with req_i & addr_ok.
- Writes:
  - Applied at the clock edge of acceptance, per byte lane where wem[k]=1.
  - data_ok = 1 for exactly one cycle after acceptance.
  - A write to an unmapped offset is ignored but still acked.
- Reads:
  - data_o is registered with the selected value and data_ok=1 in the cycle after acceptance.
  - Unmapped offsets read 0.
  - data_o = 0 in every non-ack cycle.
- Back-to-back requests on consecutive cycles are each acked one cycle later; there are no stalls.
- Outputs:
  - io_oe_o[i] = (mode==01).
  - io_out_o[i] = DATA[i] & io_oe_o[i].
- Inputs:
  - sync[i] is io_pin_i[i] after SYNC_STAGES flops, plus one extra flop prev[i] for edge detection.
  - If mode==10, DATA[i] <= sync[i] every cycle. A CPU write to DATA bit i in input mode is overridden by the sampled value.
- Edge detection:
  - Active only when mode==10.
  - rise = sync & !prev; fall = !sync & prev.
  - Set condition: set[i] = (rise & RISE_EN[i]) | (fall & FALL_EN[i]).
- PEND[i] <= (PEND[i] & !clr[i]) | set[i].
  - On the same cycle, set wins over a W1C clear.
  - Writing 0 has no effect.
- irq_o is registered: irq_o <= |PEND. Latency from pad edge to irq_o is SYNC_STAGES+2 cycles.
- Mode switch: changing mode into input does not fabricate an edge. prev is updated continuously regardless of mode.

Decomposition:
- Package gpio_pkg holds:
  - offset constants GPIO_CTRL, GPIO_DATA, GPIO_RISE_EN, GPIO_FALL_EN, GPIO_PEND;
  - mode encodings MODE_HIZ, MODE_OUT, MODE_IN.
- Sub-module gpio_sync_edge: one per pin (generate loop). It contains the SYNC_STAGES synchroniser and the prev flop, and outputs sync, rise and fall.
- The top level holds the register file, the bus FSM and PEND.

Test Plan:
- Reset/defaults: assert rst mid-transfer -> data_o=0, data_ok=0, irq_o=0, io_oe_o=0 immediately; a read of CTRL after release returns 0x0.
- Output path (NUM_IO=4): write CTRL=0x55, then DATA=0xA with wem=4'hF -> io_oe_o=4'hF, io_out_o=4'hA; data_ok pulses 1 cycle after each write.
- Byte mask: write CTRL=0xFFFF_FFFF with wem=4'b0001 -> a read of CTRL returns 0x0000_00FF (NUM_IO=4); the upper lanes are untouched.
- Rising IRQ: CTRL=0x2 (pin0 input), RISE_EN=0x1; pin0 goes 0->1 -> PEND reads 0x1 and irq_o=1 exactly 4 cycles after the pad edge; a falling edge adds nothing.
- W1C vs set collision: write PEND=0x1 in the same cycle a new rising edge is detected -> PEND stays 0x1 and irq_o stays 1. A later clear with no edge -> PEND=0, and irq_o=0 one cycle later.
- Input override and unmapped offsets: pin1 in input mode, pad=1, write DATA=0 -> the read returns bit1=1. A read at 0x14 returns 0 with data_ok=1.
